score_tally: RTL
================

Name: score_tally

Overview:
- Consumer end of the dropper score interface: collects the per-note hit levels from all droppers and turns them into game score, current combo and best combo.
- Owns the song-level state machine: idle, playing, done.
- Sits between the dropper array and the HUD/text renderer.
- Runs on frame_clk, one update per frame.

Parameters:
N_DROP, 8, number of dropper hit inputs (width of score_vec)
POINTS, 10, points added per hit
COMBO_WINDOW, 120, frames without a hit before the combo resets to 0
SONG_LEN, 3600, PLAY frames before the song is complete
SCORE_MAX, 9999, saturation ceiling of the binary score

Ports:
frame_clk  in  1  frame clock, one tick per video frame
Reset  in  1  asynchronous, active-low reset (0 = reset)
keycode  in  8  current keyboard code; 0x2C = start, 0x01 = back/abort
score_vec  in  N_DROP  dropper hit levels; bit i rises once when note i is hit, then stays high until that dropper re-arms
score_bin  out  14  binary score, 0..SCORE_MAX
score_bcd  out  16  4-digit BCD of score_bin, [15:12] = thousands
combo  out  8  current consecutive-hit combo, saturates at 255
max_combo  out  8  best combo this song
game_state  out  2  0 = IDLE, 1 = PLAY, 2 = DONE
song_done  out  1  1-frame pulse on the PLAY->DONE transition

Behaviour:
- Reset (Reset = 0, async): all outputs = 0; state = IDLE; internal prev_vec, frame_cnt and gap_cnt = 0.
- State machine, registered on frame_clk:
  - IDLE -> PLAY when keycode == 0x2C.
  - PLAY -> DONE when frame_cnt == SONG_LEN-1 (song_done = 1 for that one frame).
  - PLAY -> IDLE when keycode == 0x01 (abort; song_done stays 0).
  - DONE -> IDLE when keycode == 0x01.
  - All other cases hold state.
- IDLE:
  - prev_vec <= score_vec every frame, so bits already high at start never count.
  - score_bin, combo and max_combo hold their last values (results stay on screen).
- IDLE->PLAY transition frame:
  - score_bin, combo, max_combo, frame_cnt and gap_cnt cleared to 0.
  - prev_vec <= score_vec.
- PLAY, each frame:
  - hits = popcount(score_vec & ~prev_vec), range 0..N_DROP; then prev_vec <= score_vec.
  - Falling edges on score_vec are ignored.
  - frame_cnt increments.
  - If hits > 0:
    - score_bin <= min(score_bin + hits*POINTS, SCORE_MAX); compute at 16 bits wide so it cannot overflow before the compare.
    - combo <= min(combo + hits, 255).
    - gap_cnt <= 0.
  - If hits == 0:
    - gap_cnt increments.
    - When gap_cnt reaches COMBO_WINDOW-1, combo <= 0 and gap_cnt <= 0.
  - max_combo <= max(max_combo, next combo), same frame.
- Hits on the PLAY->DONE frame are counted. Hits on a PLAY->IDLE abort frame are not counted.
- DONE: all counters frozen; score_vec edges ignored; prev_vec tracks score_vec.
- score_bcd: registered binary-to-BCD of score_bin, valid one frame after score_bin changes. Reset value is 0x0000.
- game_state is the registered state encoding.
- keycode values other than 0x2C and 0x01 have no effect.

Optional Feature:
- SCORE_COMBO_BONUS_EN defined:
  - When the pre-update combo >= 10, each hit scores 2*POINTS.
  - Saturation at SCORE_MAX still applies.
- SCORE_COMBO_BONUS_EN undefined: every hit scores POINTS regardless of combo.

Test Plan:
- Reset = 0 mid-PLAY with score_bin = 50 -> all outputs 0 and game_state = 0 immediately, without waiting for a clock edge; after release, state is IDLE.
- score_vec = 0x01 held in IDLE, then keycode = 0x2C -> PLAY with score_bin = 0. Bit 0 still high earns nothing. Later score_vec = 0x07 -> score_bin = 20, combo = 2; score_bcd = 0x0020 one frame later.
- Three simultaneous rising bits in PLAY (score_vec 0x00 -> 0xE0) -> score_bin += 30, combo += 3.
- Hit, then 120 frames with no rising edges -> combo = 0 on the 120th gap frame; max_combo keeps its previous value.
- SONG_LEN = 16: start, then hit on frame 15 -> hit counted, game_state = 2, song_done pulses exactly one frame. keycode = 0x01 -> IDLE with score still shown. keycode = 0x2C -> score cleared.
- score_bin = 9995, then one hit -> 9999 (saturated), score_bcd = 0x9999. With SCORE_COMBO_BONUS_EN and combo = 10, one hit from score_bin = 100 -> 120.

Source files
------------

// File: rtl/score_tally.sv
// score_tally: song state machine plus score/combo tally fed by dropper hit edges.
// Optional feature: define SCORE_COMBO_BONUS_EN to double per-hit points while combo >= 10.
module score_tally #(
    parameter int N_DROP       = 8,
    parameter int POINTS       = 10,
    parameter int COMBO_WINDOW = 120,
    parameter int SONG_LEN     = 3600,
    parameter int SCORE_MAX    = 9999
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic [N_DROP-1:0] score_vec,
    output logic [13:0]       score_bin,
    output logic [15:0]       score_bcd,
    output logic [7:0]        combo,
    output logic [7:0]        max_combo,
    output logic [1:0]        game_state,
    output logic              song_done
);
    localparam int FW = $clog2(SONG_LEN);
    localparam int GW = $clog2(COMBO_WINDOW);
    localparam int HW = $clog2(N_DROP + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;
    state_t            state, state_nxt;
    logic [N_DROP-1:0] prev_vec;
    logic [FW-1:0]     frame_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [HW-1:0]     hits;
    logic              last_frame, gap_expired, counting;
    logic [15:0]       pts, score_sum;
    logic [8:0]        combo_sum;
    logic [7:0]        combo_nxt;

    function automatic logic [15:0] to_bcd(input logic [13:0] b);
        logic [13:0] th, hu, te, on;
        th = b / 14'd1000;
        hu = (b / 14'd100) % 14'd10;
        te = (b / 14'd10) % 14'd10;
        on = b % 14'd10;
        return {th[3:0], hu[3:0], te[3:0], on[3:0]};
    endfunction

    assign game_state  = state;
    assign last_frame  = frame_cnt == FW'(SONG_LEN - 1);
    assign gap_expired = gap_cnt == GW'(COMBO_WINDOW - 1);

    // Count rising edges only; bits that stay high are already scored.
    always_comb begin
        hits = '0;
        for (int i = 0; i < N_DROP; i++)
            hits = hits + HW'(score_vec[i] & ~prev_vec[i]);
    end

    // Song state machine; reaching the last frame wins over a same-frame abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (keycode == 8'h2C) ? PLAY : IDLE;
            PLAY:    state_nxt = last_frame ? DONE : (keycode == 8'h01) ? IDLE : PLAY;
            DONE:    state_nxt = (keycode == 8'h01) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next score and combo for a PLAY frame; sum kept at 16 bits so saturation sees the true total.
    always_comb begin
`ifdef SCORE_COMBO_BONUS_EN
        pts = (combo >= 8'd10) ? 16'(2 * POINTS) : 16'(POINTS);
`else
        pts = 16'(POINTS);
`endif
        score_sum = 16'(score_bin) + 16'(hits) * pts;
        combo_sum = 9'(combo) + 9'(hits);
        combo_nxt = (hits == '0) ? (gap_expired ? 8'd0 : combo)
                                 : (combo_sum > 9'd255 ? 8'd255 : combo_sum[7:0]);
        counting  = (state == PLAY) && (state_nxt != IDLE);
    end

    // State register.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Tally registers: cleared on song start, updated only on non-aborted PLAY frames.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            prev_vec  <= '0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            score_bin <= '0;
            score_bcd <= '0;
            combo     <= '0;
            max_combo <= '0;
            song_done <= 1'b0;
        end else begin
            prev_vec  <= score_vec;
            score_bcd <= to_bcd(score_bin);
            song_done <= (state == PLAY) && (state_nxt == DONE);
            if (state == IDLE && state_nxt == PLAY) begin
                frame_cnt <= '0;
                gap_cnt   <= '0;
                score_bin <= '0;
                combo     <= '0;
                max_combo <= '0;
            end else if (counting) begin
                frame_cnt <= frame_cnt + 1'b1;
                gap_cnt   <= (hits != '0 || gap_expired) ? '0 : gap_cnt + 1'b1;
                if (hits != '0)
                    score_bin <= (score_sum > 16'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
                combo     <= combo_nxt;
                max_combo <= (combo_nxt > max_combo) ? combo_nxt : max_combo;
            end
        end
    end
endmodule
